// File: rtl/alu_ctrl_md_pkg.sv
// alu_ctrl_pkg: ALU control codes, function-field constants, multiply/divide
// FSM state encoding and small decode helpers shared by the ALU control block.
// Optional feature macro: ALU_CTRL_MD_DIV_EN (enables DIV/DIVU support).
package alu_ctrl_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_ILL = 3'b011;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
`ifdef ALU_CTRL_MD_DIV_EN
        S_DIV  = 3'd2,
`endif
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } md_state_e;

    // Any funct that touches HI/LO or the multiply/divide unit.
    function automatic logic is_md_funct(input logic [5:0] f);
        logic r;
        case (f)
            F_MULT, F_MULTU, F_MFHI, F_MFLO, F_MTHI, F_MTLO: r = 1'b1;
`ifdef ALU_CTRL_MD_DIV_EN
            F_DIV, F_DIVU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Functs that launch an iterative operation.
    function automatic logic is_md_start(input logic [5:0] f);
        logic r;
        case (f)
            F_MULT, F_MULTU: r = 1'b1;
`ifdef ALU_CTRL_MD_DIV_EN
            F_DIV, F_DIVU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_funct(input logic [5:0] f);
        return (f == F_DIV) || (f == F_DIVU);
    endfunction

endpackage

// File: rtl/alu_ctrl_md_if.sv
// Instruction/operand bus and result bus of the ALU control + multiply/divide block.
// Optional feature macro: ALU_CTRL_MD_DIV_EN (enables DIV/DIVU support).
interface alu_ctrl_md_if
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             valid_in;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [2:0]       alu_ctrl;
    logic             illegal;
    logic             md_busy;
    logic             md_done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output valid_in, alu_op, funct, op_a, op_b,
        input  alu_ctrl, illegal, md_busy, md_done, stall, hi, lo
    );

    modport slave (
        input  valid_in, alu_op, funct, op_a, op_b,
        output alu_ctrl, illegal, md_busy, md_done, stall, hi, lo
    );
endinterface

// File: rtl/alu_ctrl_md_md_seq.sv
// md_seq: one-bit-per-cycle multiply/divide datapath working on operand
// magnitudes, with combinational sign correction of the final result.
// Optional feature macro: ALU_CTRL_MD_DIV_EN (restoring divider present).
module md_seq
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
`ifdef ALU_CTRL_MD_DIV_EN
    input  logic             is_div_i,
`endif
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o
);

    // Two's-complement magnitude / negation helper.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    // acc: upper product half / partial remainder; q: multiplier / quotient
    logic [WIDTH-1:0]   acc_q, acc_d, q_q, q_d, m_q, m_d;
    logic               neg_res_q, neg_res_d;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] prod_s, prod_neg_s;
    logic               a_neg_s, b_neg_s;
`ifdef ALU_CTRL_MD_DIV_EN
    logic               div_q, div_d, neg_a_q, neg_a_d;
    logic [WIDTH:0]     div_shift_s, div_diff_s;
`endif

    // Per-step arithmetic terms.
    always_comb begin
        a_neg_s   = is_signed_i & op_a_i[WIDTH-1];
        b_neg_s   = is_signed_i & op_b_i[WIDTH-1];
        mul_sum_s = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
`ifdef ALU_CTRL_MD_DIV_EN
        div_shift_s = {acc_q, q_q[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, m_q};
`endif
    end

    // Next state of the operand/partial-result registers: load, step or hold.
    always_comb begin
        acc_d     = acc_q;
        q_d       = q_q;
        m_d       = m_q;
        neg_res_d = neg_res_q;
`ifdef ALU_CTRL_MD_DIV_EN
        div_d     = div_q;
        neg_a_d   = neg_a_q;
`endif
        if (start_i) begin
            acc_d     = {WIDTH{1'b0}};
            q_d       = neg_if(op_a_i, a_neg_s);
            m_d       = neg_if(op_b_i, b_neg_s);
            neg_res_d = a_neg_s ^ b_neg_s;
`ifdef ALU_CTRL_MD_DIV_EN
            div_d     = is_div_i;
            neg_a_d   = a_neg_s;
`endif
        end else if (step_i) begin
`ifdef ALU_CTRL_MD_DIV_EN
            if (div_q) begin
                // restoring step: subtract only when the shifted remainder covers the divisor
                if (div_shift_s >= {1'b0, m_q}) begin
                    acc_d = div_diff_s[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift_s[WIDTH-1:0];
                    q_d   = {q_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = mul_sum_s[WIDTH:1];
                q_d   = {mul_sum_s[0], q_q[WIDTH-1:1]};
            end
`else
            acc_d = mul_sum_s[WIDTH:1];
            q_d   = {mul_sum_s[0], q_q[WIDTH-1:1]};
`endif
        end else begin
            acc_d = acc_q;
        end
    end

    // Operand and partial-result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= {WIDTH{1'b0}};
            q_q       <= {WIDTH{1'b0}};
            m_q       <= {WIDTH{1'b0}};
            neg_res_q <= 1'b0;
`ifdef ALU_CTRL_MD_DIV_EN
            div_q     <= 1'b0;
            neg_a_q   <= 1'b0;
`endif
        end else begin
            acc_q     <= acc_d;
            q_q       <= q_d;
            m_q       <= m_d;
            neg_res_q <= neg_res_d;
`ifdef ALU_CTRL_MD_DIV_EN
            div_q     <= div_d;
            neg_a_q   <= neg_a_d;
`endif
        end
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
        prod_s     = {acc_q, q_q};
        prod_neg_s = ~prod_s + {{(2*WIDTH-1){1'b0}}, 1'b1};
        res_hi_o   = acc_q;
        res_lo_o   = q_q;
`ifdef ALU_CTRL_MD_DIV_EN
        if (div_q) begin
            res_lo_o = neg_if(q_q, neg_res_q);
            res_hi_o = neg_if(acc_q, neg_a_q);
        end else if (neg_res_q) begin
            {res_hi_o, res_lo_o} = prod_neg_s;
        end else begin
            {res_hi_o, res_lo_o} = prod_s;
        end
`else
        if (neg_res_q) begin
            {res_hi_o, res_lo_o} = prod_neg_s;
        end else begin
            {res_hi_o, res_lo_o} = prod_s;
        end
`endif
    end

endmodule

// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: ALU control decode plus HI/LO multiply/divide sequencing and
// pipeline stall generation. Iteration datapath lives in md_seq.
// Optional feature macro: ALU_CTRL_MD_DIV_EN (DIV/DIVU accepted when defined,
// otherwise decoded as illegal).
module alu_ctrl_md
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    alu_ctrl_md_if.slave  bus
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] res_hi_s, res_lo_s;
    logic [2:0]       alu_ctrl_s;
    logic             illegal_s, is_md_s, can_issue_s, start_op_s, div0_s;
    logic             seq_start_s, seq_step_s, md_busy_s, md_done_s, stall_s, op_signed_s;

    // ALU control decode; MD functs select ADD so the ALU stays harmless.
    always_comb begin
        alu_ctrl_s = ALU_ILL;
        illegal_s  = 1'b0;
        case (bus.alu_op)
            ALUOP_ADD: alu_ctrl_s = ALU_ADD;
            ALUOP_SUB: alu_ctrl_s = ALU_SUB;
            ALUOP_OR:  alu_ctrl_s = ALU_OR;
            ALUOP_RTYPE: begin
                case (bus.funct)
                    F_ADD: alu_ctrl_s = ALU_ADD;
                    F_SUB: alu_ctrl_s = ALU_SUB;
                    F_AND: alu_ctrl_s = ALU_AND;
                    F_OR:  alu_ctrl_s = ALU_OR;
                    F_NOR: alu_ctrl_s = ALU_NOR;
                    F_SLT: alu_ctrl_s = ALU_SLT;
                    F_MULT, F_MULTU, F_MFHI, F_MFLO, F_MTHI, F_MTLO: alu_ctrl_s = ALU_ADD;
`ifdef ALU_CTRL_MD_DIV_EN
                    F_DIV, F_DIVU: alu_ctrl_s = ALU_ADD;
`endif
                    default: begin
                        alu_ctrl_s = ALU_ILL;
                        illegal_s  = 1'b1;
                    end
                endcase
            end
            default: alu_ctrl_s = ALU_ILL;
        endcase
    end

    // Issue qualification: MD instruction present, unit free, divide-by-zero shortcut.
    always_comb begin
        is_md_s     = bus.valid_in && (bus.alu_op == ALUOP_RTYPE) && is_md_funct(bus.funct);
        can_issue_s = (state_q == S_IDLE) || (state_q == S_DONE);
        stall_s     = is_md_s && md_busy_s;
        start_op_s  = is_md_s && can_issue_s && is_md_start(bus.funct);
        op_signed_s = (bus.funct == F_MULT) || (bus.funct == F_DIV);
`ifdef ALU_CTRL_MD_DIV_EN
        div0_s      = start_op_s && is_div_funct(bus.funct) && (bus.op_b == {WIDTH{1'b0}});
`else
        div0_s      = 1'b0;
`endif
        seq_start_s = start_op_s && !div0_s;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (!start_op_s) begin
                    state_d = S_IDLE;
                end else if (div0_s) begin
                    state_d = S_DONE;
`ifdef ALU_CTRL_MD_DIV_EN
                end else if (is_div_funct(bus.funct)) begin
                    state_d = S_DIV;
`endif
                end else begin
                    state_d = S_MUL;
                end
            end
            S_MUL:   state_d = (cnt_q == LAST_CNT) ? S_FIX : S_MUL;
`ifdef ALU_CTRL_MD_DIV_EN
            S_DIV:   state_d = (cnt_q == LAST_CNT) ? S_FIX : S_DIV;
`endif
            S_FIX:   state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        md_done_s = (state_q == S_DONE);
`ifdef ALU_CTRL_MD_DIV_EN
        seq_step_s = (state_q == S_MUL) || (state_q == S_DIV);
`else
        seq_step_s = (state_q == S_MUL);
`endif
        md_busy_s = seq_step_s || (state_q == S_FIX);
    end

    // HI/LO and iteration counter next values.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == S_FIX) begin
            hi_d = res_hi_s;
            lo_d = res_lo_s;
        end else if (div0_s) begin
            hi_d = bus.op_a;
            lo_d = {WIDTH{1'b1}};
        end else if (is_md_s && can_issue_s && (bus.funct == F_MTHI)) begin
            hi_d = bus.op_a;
        end else if (is_md_s && can_issue_s && (bus.funct == F_MTLO)) begin
            lo_d = bus.op_a;
        end else begin
            hi_d = hi_q;
        end
        if (start_op_s) begin
            cnt_d = {CW{1'b0}};
        end else if (seq_step_s) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // HI/LO and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q  <= {WIDTH{1'b0}};
            lo_q  <= {WIDTH{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_d;
        end
    end

    md_seq #(.WIDTH(WIDTH)) u_md_seq (
        .clk         (clk),
        .reset       (reset),
        .start_i     (seq_start_s),
`ifdef ALU_CTRL_MD_DIV_EN
        .is_div_i    (is_div_funct(bus.funct)),
`endif
        .is_signed_i (op_signed_s),
        .op_a_i      (bus.op_a),
        .op_b_i      (bus.op_b),
        .step_i      (seq_step_s),
        .res_hi_o    (res_hi_s),
        .res_lo_o    (res_lo_s)
    );

    assign bus.alu_ctrl = alu_ctrl_s;
    assign bus.illegal  = illegal_s;
    assign bus.md_busy  = md_busy_s;
    assign bus.md_done  = md_done_s;
    assign bus.stall    = stall_s;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule
